// File: rtl/filter_ctrl_pkg.sv
// Shared definitions for the frame-synchronous filter controller:
// display-select encodings, controller state and config legality check.
package filter_ctrl_pkg;

  localparam logic [5:0] DISP_RGB  = 6'd0;
  localparam logic [5:0] DISP_GREY = 6'd1;
  localparam logic [5:0] DISP_THR1 = 6'd2;
  localparam logic [5:0] DISP_BLUR = 6'd4;
  localparam logic [5:0] DISP_THR2 = 6'd8;
  localparam logic [5:0] DISP_EDGE = 6'd16;
  localparam logic [5:0] DISP_MIX  = 6'd32;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ctrl_state_t;

  // Zero selects passthrough; otherwise exactly one stage may be selected.
  function automatic logic is_legal_display(input logic [5:0] disp);
    return (disp & (disp - 6'd1)) == 6'd0;
  endfunction

endpackage

// File: rtl/frame_edge_counter.sv
// Frame boundary detector and per-frame edge-pixel accumulator.
// boundary is combinational in the VSync-rise cycle; all its effects land one cycle later.
module frame_edge_counter #(
  parameter int CNT_W  = 22,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             vde,
  input  logic             process_in,
  output logic             boundary,
  output logic [CNT_W-1:0] acc,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_start
);

  logic vs_q;
  logic pixel_hit;

  assign pixel_hit = vde & process_in;
  assign boundary  = (vsync == VS_POL) && (vs_q != VS_POL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= ~VS_POL;
      acc         <= '0;
      edge_count  <= '0;
      frame_count <= '0;
      frame_start <= 1'b0;
    end else begin
      vs_q        <= vsync;
      frame_start <= boundary;
      if (boundary) begin
        edge_count  <= acc;
        frame_count <= frame_count + CNT_W'(1);
        // A hit in the boundary cycle belongs to the new frame.
        acc         <= pixel_hit ? CNT_W'(1) : '0;
      end else if (pixel_hit && (acc != '1)) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame-synchronous config controller: host config is held pending and applied
// only at a frame boundary; optional closed-loop auto-threshold from edge counts.
module filter_frame_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int              CNT_W      = 22,
  parameter logic [7:0]      DEF_THRESH = 8'h80,
  parameter logic [CNT_W-1:0] TGT_LO    = CNT_W'(20000),
  parameter logic [CNT_W-1:0] TGT_HI    = CNT_W'(60000),
  parameter logic [7:0]      STEP       = 8'd4,
  parameter bit              VS_POL     = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VSync,
  input  logic             VDE,
  input  logic             ProcessIn,
  input  logic             CfgValid,
  output logic             CfgReady,
  input  logic [5:0]       CfgDisplay,
  input  logic [7:0]       CfgThreshold,
  input  logic             CfgAuto,
  output logic             CfgError,
  output logic [5:0]       Display,
  output logic [7:0]       Threshold,
  output logic             AutoEn,
  output logic             FrameStart,
  output logic [CNT_W-1:0] EdgeCount,
  output logic [CNT_W-1:0] FrameCount
);

  ctrl_state_t      state_q, state_d;
  logic             boundary;
  logic [CNT_W-1:0] acc;
  logic             cfg_fire, cfg_legal, apply;
  logic             seen_full;
  logic [5:0]       pend_disp;
  logic [7:0]       pend_thr;
  logic             pend_auto;
  logic [8:0]       thr_sum;
  logic [7:0]       thr_up, thr_dn;

  frame_edge_counter #(
    .CNT_W  (CNT_W),
    .VS_POL (VS_POL)
  ) u_counter (
    .clk         (CLK),
    .rst         (RST),
    .vsync       (VSync),
    .vde         (VDE),
    .process_in  (ProcessIn),
    .boundary    (boundary),
    .acc         (acc),
    .edge_count  (EdgeCount),
    .frame_count (FrameCount),
    .frame_start (FrameStart)
  );

  assign cfg_fire  = CfgValid && CfgReady;
  assign cfg_legal = is_legal_display(CfgDisplay);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_fire && cfg_legal) state_d = PENDING;
      PENDING: if (boundary)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CfgReady = (state_q == IDLE);
    apply    = (state_q == PENDING) && boundary;
  end

  // Saturating threshold steps for the auto loop.
  always_comb begin
    thr_sum = {1'b0, Threshold} + {1'b0, STEP};
    thr_up  = thr_sum[8] ? 8'hFF : thr_sum[7:0];
    thr_dn  = (Threshold < STEP) ? 8'h00 : (Threshold - STEP);
  end

  // NOTE: pending config is reset too, so a reset mid-transfer can never
  // apply stale host data at the next boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Display   <= DISP_RGB;
      Threshold <= DEF_THRESH;
      AutoEn    <= 1'b0;
      CfgError  <= 1'b0;
      seen_full <= 1'b0;
      pend_disp <= DISP_RGB;
      pend_thr  <= DEF_THRESH;
      pend_auto <= 1'b0;
    end else begin
      CfgError <= cfg_fire && !cfg_legal;
      if (cfg_fire && cfg_legal) begin
        pend_disp <= CfgDisplay;
        pend_thr  <= CfgThreshold;
        pend_auto <= CfgAuto;
      end
      if (boundary) begin
        if (apply) begin
          Display   <= pend_disp;
          Threshold <= pend_thr;
          AutoEn    <= pend_auto;
          // Enabling auto restarts measurement under the new settings.
          seen_full <= !pend_auto;
        end else begin
          seen_full <= 1'b1;
          if (AutoEn && seen_full) begin
            if (acc > TGT_HI)      Threshold <= thr_up;
            else if (acc < TGT_LO) Threshold <= thr_dn;
          end
        end
      end
    end
  end

endmodule
